// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide execute unit.
//   Ports: clk/rst (async, active-high); start/flush/funct3/rs1_data/rs2_data/rd_in
//   request side; busy/done/reg_write/result/rd_out writeback side.
//   Latency: one bit per cycle, so done arrives N+1 cycles after accept. Divide by
//   zero and signed overflow finish one cycle after accept.
//   Backpressure: busy is high while an op is in flight. start is ignored while
//   busy, and no request is queued. flush aborts the op in any state.
//   Optional feature: when MULDIV_FAST_MUL_EN is defined, MUL* ops use a
//   single-cycle combinational product and finish one cycle after accept.
module muldiv_unit #(
  parameter int N     = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         flush,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  input  logic [4:0]   rd_in,
  output logic         busy,
  output logic         done,
  output logic         reg_write,
  output logic [N-1:0] result,
  output logic [4:0]   rd_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  // Latched operation context
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic             sa_q, sb_q, special_q;
  logic [CNT_W-1:0] cnt;
  // hi/lo: product {hi,lo} for multiplies, remainder/quotient for divides
  logic [N-1:0]     hi, lo, opnd;
  logic [N-1:0]     result_q;
  logic [4:0]       rd_out_q;

  // ---------------- accept-time decode ----------------
  logic         is_div_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic [N-1:0] mag_a, mag_b, special_val;
  logic         b_zero, div_ovf, special_in, fast_in, accept;
  logic [2*N-1:0] fast_prod;

  assign is_div_in = funct3[2];
  // MULHU and the unsigned divides treat A as unsigned; only MUL/MULH sign-extend B
  assign sgn_a_in  = is_div_in ? ~funct3[0] : (funct3 != 3'b011);
  assign sgn_b_in  = is_div_in ? ~funct3[0] : ~funct3[1];
  assign neg_a_in  = sgn_a_in & rs1_data[N-1];
  assign neg_b_in  = sgn_b_in & rs2_data[N-1];
  assign mag_a     = neg_a_in ? -rs1_data : rs1_data;
  assign mag_b     = neg_b_in ? -rs2_data : rs2_data;

  assign b_zero  = (rs2_data == '0);
  assign div_ovf = ~funct3[0] && (rs1_data == {1'b1, {(N-1){1'b0}}}) && (rs2_data == '1);
  assign special_in = is_div_in & (b_zero | div_ovf);
  // Zero divisor: quotient all ones, remainder A. Overflow: quotient A, remainder 0.
  assign special_val = b_zero ? (funct3[1] ? rs1_data : '1)
                              : (funct3[1] ? '0 : rs1_data);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_in   = ~is_div_in;
  assign fast_prod = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
`else
  assign fast_in   = 1'b0;
  assign fast_prod = '0;
`endif

  assign accept = (state == IDLE) && start && !flush;

  // ---------------- iteration datapath ----------------
  logic [N:0]   mul_sum;
  logic [N:0]   div_shift;
  logic [N+1:0] div_trial;
  logic         div_ok;

  assign mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
  assign div_shift = {hi, lo[N-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opnd};
  assign div_ok    = ~div_trial[N+1];

  // ---------------- sign fix-up and result select ----------------
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   mul_res, div_val, div_res, final_val;
  logic           div_neg;

  assign prod_fix  = (sa_q ^ sb_q) ? -{hi, lo} : {hi, lo};
  assign mul_res   = (f3_q[1:0] == 2'b00) ? prod_fix[N-1:0] : prod_fix[2*N-1:N];
  assign div_val   = f3_q[1] ? hi : lo;
  assign div_neg   = f3_q[1] ? sa_q : (sa_q ^ sb_q);
  assign div_res   = div_neg ? -div_val : div_val;
  assign final_val = special_q ? lo : (f3_q[2] ? div_res : mul_res);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (special_in | fast_in) ? DONE : CALC;
      CALC: if (cnt == CNT_W'(N-1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE) && !flush;
    // Present the fresh result during the done cycle, then hold it afterwards
    result    = done ? final_val : result_q;
    rd_out    = done ? rd_q : rd_out_q;
    reg_write = done && (rd_out != 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q      <= '0;
      rd_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      special_q <= 1'b0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
    end else begin
      if (accept) begin
        f3_q      <= funct3;
        rd_q      <= rd_in;
        sa_q      <= neg_a_in;
        sb_q      <= neg_b_in;
        special_q <= special_in;
        cnt       <= '0;
        hi        <= '0;
        lo        <= is_div_in ? mag_a : mag_b;
        opnd      <= is_div_in ? mag_b : mag_a;
        if (special_in) lo <= special_val;
        if (fast_in) {hi, lo} <= fast_prod;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
        if (f3_q[2]) begin
          hi <= div_ok ? div_trial[N-1:0] : div_shift[N-1:0];
          lo <= {lo[N-2:0], div_ok};
        end else begin
          {hi, lo} <= {mul_sum, lo[N-1:1]};
        end
      end
      if (done) begin
        result_q <= final_val;
        rd_out_q <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_in;
  logic        busy, done, reg_write;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic [6:0]  lat;
  } exp_t;
  exp_t sb[$];

  muldiv_unit #(.N(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_in(rd_in),
    .busy(busy), .done(done), .reg_write(reg_write), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Reference model built on native 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sbv; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sbv; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) return 1;
`endif
    return 33;
  endfunction

  // Drive one request for a single cycle; optionally record its expectation
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push);
    exp_t e;
    @(negedge clk);
    funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
    e.res = ref_op(f, a, b);
    e.rd  = rd;
    e.rw  = (rd != 5'd0);
    e.lat = 7'(exp_lat(f, a, b));
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; cyc is the cycle offset from the accept cycle
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, reg_write, result, rd_out} !== 40'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b rw=%b res=%h rd=%0d, want all zero",
               busy, done, reg_write, result, rd_out);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_mul;
    logic [2:0]  f [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [4:0]  r [4];
    exp_t e;
    int cyc;
    f = '{3'd0, 3'd1, 3'd3, 3'd0};
    a = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'd3};
    b = '{32'd6, 32'd2, 32'd2, 32'd3};
    r = '{5'd5, 5'd7, 5'd8, 5'd0};
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], r[i], 1'b1);
      wait_done(1, cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== int'(e.lat)) begin errors++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, cyc, e.lat); end
      checks++;
      if (result !== e.res) begin errors++; $display("FAIL mul_result[%0d]: got %h want %h", i, result, e.res); end
      checks++;
      if ({reg_write, rd_out} !== {e.rw, e.rd}) begin
        errors++;
        $display("FAIL mul_writeback[%0d]: got rw=%b rd=%0d want rw=%b rd=%0d", i, reg_write, rd_out, e.rw, e.rd);
      end
      if (i == 0) begin
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 32'd42 || done !== 1'b0 || busy !== 1'b0) begin
          errors++;
          $display("FAIL result_hold: got res=%h done=%b busy=%b want 0000002a 0 0", result, done, busy);
        end
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  f [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] x [4];
    exp_t e;
    int cyc;
    f = '{3'd4, 3'd6, 3'd5, 3'd7};
    a = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    b = '{32'd2, 32'd2, 32'd7, 32'd7};
    x = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 5'd10 + 5'(i), 1'b1);
      wait_done(1, cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== 33) begin errors++; $display("FAIL div_latency[%0d]: got %0d want 33", i, cyc); end
      checks++;
      if (result !== x[i] || result !== e.res) begin
        errors++; $display("FAIL div_result[%0d]: got %h want %h", i, result, x[i]);
      end
      checks++;
      if (reg_write !== 1'b1 || rd_out !== e.rd) begin
        errors++; $display("FAIL div_writeback[%0d]: got rw=%b rd=%0d want 1 %0d", i, reg_write, rd_out, e.rd);
      end
    end
  endtask

  task automatic test_special;
    logic [2:0]  f [4];
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] x [4];
    exp_t e;
    int cyc;
    f = '{3'd5, 3'd6, 3'd4, 3'd6};
    a = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    b = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    x = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      issue(f[i], a[i], b[i], 5'd20, 1'b1);
      wait_done(1, cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== 1) begin errors++; $display("FAIL special_latency[%0d]: got %0d want 1", i, cyc); end
      checks++;
      if (result !== x[i] || result !== e.res) begin
        errors++; $display("FAIL special_result[%0d]: got %h want %h", i, result, x[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [2:0]  f;
    logic [31:0] a, b;
    exp_t e;
    int cyc;
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 4 == 1) a = -a;
      issue(f, a, b, 5'($urandom_range(0, 31)), 1'b1);
      wait_done(1, cyc);
      e = sb.pop_front();
      checks++;
      if (cyc !== int'(e.lat) || result !== e.res || reg_write !== e.rw || rd_out !== e.rd) begin
        errors++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h: got lat=%0d res=%h rw=%b rd=%0d want lat=%0d res=%h rw=%b rd=%0d",
                 i, f, a, b, cyc, result, reg_write, rd_out, e.lat, e.res, e.rw, e.rd);
      end
    end
  endtask

  task automatic test_flush;
    exp_t e;
    int cyc, n0;
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 1'b0);
    cyc = 1;
    n0 = done_cnt;
    while (cyc < 10) begin @(negedge clk); cyc++; end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle: got busy=%b want 0", busy); end
    checks++;
    if (done_cnt !== n0) begin errors++; $display("FAIL flush_no_done: got %0d done pulses want 0", done_cnt - n0); end
    issue(3'd5, 32'd100, 32'd7, 5'd6, 1'b1);
    wait_done(1, cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 33 || result !== e.res) begin
      errors++; $display("FAIL flush_restart: got lat=%0d res=%h want lat=33 res=%h", cyc, result, e.res);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int cyc, n0;
    issue(3'd5, 32'd100, 32'd7, 5'd3, 1'b1);
    repeat (4) @(negedge clk);
    funct3 = 3'd5; rs1_data = 32'd50; rs2_data = 32'd5; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== 33 || result !== e.res || rd_out !== e.rd) begin
      errors++;
      $display("FAIL busy_start_ignored: got lat=%0d res=%h rd=%0d want lat=33 res=%h rd=%0d",
               cyc, result, rd_out, e.res, e.rd);
    end
    @(negedge clk);
    n0 = done_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== n0) begin errors++; $display("FAIL busy_no_queue: got %0d extra done pulses want 0", done_cnt - n0); end
  endtask

  task automatic test_rst_midop;
    exp_t e;
    int cyc, n0;
    issue(3'd0, 32'd7, 32'd6, 5'd5, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_out !== 5'd0) begin
      errors++;
      $display("FAIL rst_midop: got busy=%b done=%b res=%h rd=%0d want 0 0 0 0", busy, done, result, rd_out);
    end
    @(negedge clk);
    rst = 1'b0;
    n0 = done_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt !== n0) begin errors++; $display("FAIL rst_no_done: got %0d done pulses want 0", done_cnt - n0); end
    issue(3'd0, 32'd7, 32'd6, 5'd5, 1'b1);
    wait_done(1, cyc);
    e = sb.pop_front();
    checks++;
    if (cyc !== int'(e.lat) || result !== 32'd42 || reg_write !== 1'b1) begin
      errors++;
      $display("FAIL rst_recover: got lat=%0d res=%h rw=%b want lat=%0d res=0000002a rw=1", cyc, result, reg_write, e.lat);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; rs1_data = '0; rs2_data = '0; rd_in = '0;
    test_reset;
    test_mul;
    test_div;
    test_special;
    test_random;
    test_flush;
    test_back_to_back;
    test_rst_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
